// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the SR/JK flip-flop control blocks.
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    HOLDOFF = 2'd3
  } sr_arb_state_t;

  localparam int unsigned SR_PRIO_SET   = 0;
  localparam int unsigned SR_PRIO_RESET = 1;

  localparam int unsigned SR_HOLDOFF_W  = 8;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, stability counter and registered rising-edge flag.
module debounce_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic stable,
  output logic rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          stable_prev;
  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta        <= 1'b0;
      sync        <= 1'b0;
      stable      <= 1'b0;
      stable_prev <= 1'b0;
      count       <= '0;
    end else begin
      meta        <= btn;
      sync        <= meta;
      stable_prev <= stable;
      // Any sample matching the accepted level restarts the stability window.
      if (sync == stable) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        stable <= ~stable;
        count  <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign rise = stable & ~stable_prev;

endmodule

// File: rtl/sr_debounce_arbiter.sv
// Debounces set/reset buttons and issues mutually exclusive one-cycle s/r pulses with hold-off.
module sr_debounce_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLDOFF_CYCLES  = 4,
  parameter int unsigned PRIORITY_RESET  = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic set_btn_in,
  input  logic rst_btn_in,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam logic PRIO_R = (PRIORITY_RESET == SR_PRIO_RESET);
  localparam logic [SR_HOLDOFF_W-1:0] HOLD_LAST = SR_HOLDOFF_W'(HOLDOFF_CYCLES - 1);

  logic set_stable, rst_stable;
  logic set_rise, rst_rise;
  logic set_pending, rst_pending;
  logic idle, go_set, go_rst, take_set, take_rst;

  sr_arb_state_t                state;
  logic [SR_HOLDOFF_W-1:0]      hold_cnt;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_set_db (
    .clock (clock),
    .reset (reset),
    .btn   (set_btn_in),
    .stable(set_stable),
    .rise  (set_rise)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_rst_db (
    .clock (clock),
    .reset (reset),
    .btn   (rst_btn_in),
    .stable(rst_stable),
    .rise  (rst_rise)
  );

  always_comb begin
    idle     = (state == IDLE);
    go_set   = idle & set_pending & (~rst_pending | ~PRIO_R);
    go_rst   = idle & rst_pending & (~set_pending | PRIO_R);
    // A tie clears both flags; the loser is discarded.
    take_set = idle & set_pending;
    take_rst = idle & rst_pending;
    conflict = idle & set_pending & rst_pending;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      set_pending <= 1'b0;
      rst_pending <= 1'b0;
      state       <= IDLE;
      hold_cnt    <= '0;
      s           <= 1'b0;
      r           <= 1'b0;
      busy        <= 1'b0;
    end else begin
      set_pending <= (set_pending & ~take_set) | set_rise;
      rst_pending <= (rst_pending & ~take_rst) | rst_rise;
      s           <= 1'b0;
      r           <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go_set) begin
            state <= PULSE_S;
            s     <= 1'b1;
            busy  <= 1'b1;
          end else if (go_rst) begin
            state <= PULSE_R;
            r     <= 1'b1;
            busy  <= 1'b1;
          end
        end
        PULSE_S, PULSE_R: begin
          state    <= HOLDOFF;
          hold_cnt <= '0;
        end
        HOLDOFF: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_debounce_arbiter.sv
// Directed bench for sr_debounce_arbiter: one instance per tie-break rule, shared button stimulus.
module tb_sr_debounce_arbiter;

  logic clock = 1'b0;
  logic reset;
  logic set_btn_in, rst_btn_in;
  logic s1, r1, busy1, conf1;
  logic s0, r0, busy0, conf0;

  always #5 clock = ~clock;

  sr_debounce_arbiter #(
    .DEBOUNCE_CYCLES(16),
    .HOLDOFF_CYCLES (4),
    .PRIORITY_RESET (1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .set_btn_in(set_btn_in),
    .rst_btn_in(rst_btn_in),
    .s         (s1),
    .r         (r1),
    .busy      (busy1),
    .conflict  (conf1)
  );

  sr_debounce_arbiter #(
    .DEBOUNCE_CYCLES(16),
    .HOLDOFF_CYCLES (4),
    .PRIORITY_RESET (0)
  ) dut_sprio (
    .clock     (clock),
    .reset     (reset),
    .set_btn_in(set_btn_in),
    .rst_btn_in(rst_btn_in),
    .s         (s0),
    .r         (r0),
    .busy      (busy0),
    .conflict  (conf0)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int tick_n  = 0;
  int s1_cnt, r1_cnt, b1_cnt, c1_cnt, s1_at, r1_at, c1_at;
  int s0_cnt, r0_cnt, c0_cnt, ovl_cnt;
  int smp;
  logic stable_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    s1_cnt = 0; r1_cnt = 0; b1_cnt = 0; c1_cnt = 0;
    s1_at = -1; r1_at = -1; c1_at = -1;
    s0_cnt = 0; r0_cnt = 0; c0_cnt = 0; ovl_cnt = 0;
    stable_seen = 1'b0;
  endtask

  // Advance to the next falling edge and record what the outputs show there.
  task automatic tick();
    @(negedge clock);
    tick_n++;
    if (s1 === 1'b1) begin s1_cnt++; s1_at = tick_n; end
    if (r1 === 1'b1) begin r1_cnt++; r1_at = tick_n; end
    if (busy1 === 1'b1) b1_cnt++;
    if (conf1 === 1'b1) begin c1_cnt++; c1_at = tick_n; end
    if (s0 === 1'b1) s0_cnt++;
    if (r0 === 1'b1) r0_cnt++;
    if (conf0 === 1'b1) c0_cnt++;
    if ((s1 & r1) === 1'b1 || (s0 & r0) === 1'b1) ovl_cnt++;
    if (dut.u_set_db.stable === 1'b1) stable_seen = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    clear_mon();
    reset = 1'b1;
    set_btn_in = 1'b0;
    rst_btn_in = 1'b0;
    ticks(3);
    check_eq("reset_s", s1, 0);
    check_eq("reset_r", r1, 0);
    check_eq("reset_busy", busy1, 0);
    check_eq("reset_conflict", conf1, 0);
    check_eq("reset_stable", dut.u_set_db.stable, 0);
    reset = 1'b0;
    ticks(3);

    // Clean press
    clear_mon();
    set_btn_in = 1'b1;
    smp = tick_n + 1;
    ticks(40);
    set_btn_in = 1'b0;
    ticks(30);
    check_eq("clean_s_count", s1_cnt, 1);
    check_eq("clean_s_latency", s1_at - smp, 19);
    check_eq("clean_r_count", r1_cnt, 0);
    check_eq("clean_busy_cycles", b1_cnt, 5);

    // Glitch shorter than the debounce window
    clear_mon();
    set_btn_in = 1'b1;
    ticks(10);
    set_btn_in = 1'b0;
    ticks(40);
    check_eq("glitch_s_count", s1_cnt, 0);
    check_eq("glitch_stable", stable_seen, 0);

    // Bounce then settle high
    clear_mon();
    for (int i = 0; i < 10; i++) begin
      rst_btn_in = (i % 2 == 0);
      ticks(3);
    end
    check_eq("bounce_no_early_r", r1_cnt, 0);
    rst_btn_in = 1'b1;
    smp = tick_n + 1;
    ticks(40);
    check_eq("bounce_r_count", r1_cnt, 1);
    check_eq("bounce_r_latency", r1_at - smp, 19);
    check_eq("bounce_s_count", s1_cnt, 0);
    rst_btn_in = 1'b0;
    ticks(30);

    // Simultaneous press on both buttons
    clear_mon();
    set_btn_in = 1'b1;
    rst_btn_in = 1'b1;
    ticks(40);
    check_eq("tie_r_conflict", c1_cnt, 1);
    check_eq("tie_r_r_count", r1_cnt, 1);
    check_eq("tie_r_s_count", s1_cnt, 0);
    check_eq("tie_r_conflict_lead", r1_at - c1_at, 1);
    check_eq("tie_s_conflict", c0_cnt, 1);
    check_eq("tie_s_s_count", s0_cnt, 1);
    check_eq("tie_s_r_count", r0_cnt, 0);
    set_btn_in = 1'b0;
    rst_btn_in = 1'b0;
    ticks(30);

    // Reset request debounced during the hold-off after a set pulse
    clear_mon();
    set_btn_in = 1'b1;
    ticks(3);
    rst_btn_in = 1'b1;
    ticks(40);
    check_eq("b2b_s_count", s1_cnt, 1);
    check_eq("b2b_r_count", r1_cnt, 1);
    check_eq("b2b_spacing", r1_at - s1_at, 6);
    check_eq("b2b_conflict", c1_cnt, 0);
    check_eq("overlap", ovl_cnt, 0);
    set_btn_in = 1'b0;
    rst_btn_in = 1'b0;
    ticks(30);

    // Reset in the PULSE_S cycle with the button still held
    clear_mon();
    set_btn_in = 1'b1;
    ticks(20);
    check_eq("midop_pulse_seen", s1, 1);
    reset = 1'b1;
    tick();
    check_eq("midop_s", s1, 0);
    check_eq("midop_busy", busy1, 0);
    check_eq("midop_pending", dut.set_pending, 0);
    clear_mon();
    reset = 1'b0;
    smp = tick_n + 1;
    ticks(40);
    check_eq("midop_repress_count", s1_cnt, 1);
    check_eq("midop_repress_latency", s1_at - smp, 19);
    set_btn_in = 1'b0;
    ticks(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_debounce_arbiter.md
# sr_debounce_arbiter

Upstream command stage for the SR flip-flop. It converts two raw, bouncing push-button inputs into clean, mutually exclusive one-cycle set (`s`) and reset (`r`) pulses, which drive the flip-flop's `s`/`r` inputs directly. The block synchronizes and debounces each input and arbitrates simultaneous requests. It never drives the illegal `s=r=1` combination and enforces a hold-off gap between commands.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples needed to accept a level change. Legal range is 2..65535.
- `HOLDOFF_CYCLES`, default 4: idle cycles forced after every output pulse. Legal range is 1..255.
- `PRIORITY_RESET`, default 1: tie-break rule. 1 = `r` wins a simultaneous request; 0 = `s` wins.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `set_btn_in`  in  1  raw asynchronous set button, active-high.
- `rst_btn_in`  in  1  raw asynchronous reset button, active-high.
- `s`  out  1  one-cycle set pulse to the flip-flop.
- `r`  out  1  one-cycle reset pulse to the flip-flop.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `conflict`  out  1  one-cycle flag: both requests were pending in the same IDLE cycle.

## Operation
- **Synchronizer:** a 2-flop synchronizer per input, giving `sync` = raw delayed 2 cycles.
- **Debounce, per channel:**
  - Holds a `stable` level and a counter of width `$clog2(DEBOUNCE_CYCLES)`.
  - If `sync == stable`, the counter clears.
  - Otherwise the counter increments.
  - When the counter equals `DEBOUNCE_CYCLES-1` and `sync != stable`, `stable` toggles and the counter clears.
  - Any bounce back to the `stable` value restarts the count from 0.
- **Edge detect:** the registered rising edge of `stable` sets that channel's `pending` flag.
  - Falling edges are ignored.
  - `pending` is one deep; a rising edge while already pending is dropped.
- **FSM states:** IDLE, PULSE_S, PULSE_R, HOLDOFF.
- **IDLE transitions:**
  - Only `set` pending: go to PULSE_S and clear `set` pending.
  - Only `rst` pending: go to PULSE_R and clear `rst` pending.
  - Both pending: go to the winner's PULSE state and clear both flags. The loser is discarded, and `conflict` = 1 for that cycle.
- **PULSE_S / PULSE_R:** `s` or `r` = 1 for exactly one cycle, then HOLDOFF.
- **HOLDOFF:**
  - A counter runs `HOLDOFF_CYCLES` cycles, then the FSM returns to IDLE.
  - Edges arriving during PULSE or HOLDOFF still set `pending` and are serviced in IDLE.
- **Invariant:** `s & r` is never 1.
- **Registered outputs:** `s`, `r`, `busy` and `conflict` are decoded from registered state only, with no combinational path from inputs.
- **Reset behaviour:**
  - Synchronizers, `stable`, counters, `pending`, FSM (IDLE) and all outputs go to 0.
  - Reset mid-pulse or mid-holdoff aborts the operation immediately; outputs are 0 in the cycle after the reset edge.
  - A button held high through reset is accepted as a fresh press once debounced after reset.

## Timing
- Latency from raw input rising and staying high to the output pulse:
  - Raw sampled high at edge k: `sync` = 1 after edge k+1.
  - `stable` = 1 after edge k+1+`DEBOUNCE_CYCLES`.
  - `pending` = 1 after edge k+2+`DEBOUNCE_CYCLES`.
  - `s` = 1 in the cycle after edge k+3+`DEBOUNCE_CYCLES`, when the FSM is IDLE.
- Pulse width is exactly 1 cycle.
- Minimum spacing between consecutive output pulses is `HOLDOFF_CYCLES`+2 cycles, rising edge to rising edge.
- `busy` rises with the pulse cycle and falls after the last HOLDOFF cycle.
- `conflict` coincides with the IDLE cycle that resolves the tie, one cycle before the pulse.

## Structure
- **Shared package `sr_ctrl_pkg`:**
  - FSM state enum `sr_arb_state_t` (IDLE, PULSE_S, PULSE_R, HOLDOFF).
  - Constants `SR_PRIO_SET` = 0 and `SR_PRIO_RESET` = 1.
  - The package is reused by the later SR/JK control blocks.
- **Sub-module `debounce_channel`:**
  - Contains the synchronizer, debounce counter, `stable` register and rising-edge output.
  - Takes parameter `DEBOUNCE_CYCLES`.
  - Instantiated twice.
- **Top level:** contains the pending flags, FSM and hold-off counter.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 16 and `HOLDOFF_CYCLES` = 4.
- **Clean press:** `set_btn_in` 0→1, held 40 cycles → exactly one `s` pulse, 19 cycles after the sampling edge; `r` = 0 throughout; `busy` high for 5 cycles.
- **Bounce:** `rst_btn_in` toggles every 3 cycles for 30 cycles, then holds 1 → no pulse during bouncing; one `r` pulse 19 cycles after the final rise.
- **Glitch:** `set_btn_in` high for 10 cycles only → no `s` pulse, and `stable` stays 0.
- **Simultaneous:** both buttons rise on the same edge with `PRIORITY_RESET` = 1 → `conflict` pulses once, one `r` pulse, no `s` pulse. Repeat with `PRIORITY_RESET` = 0 → one `s` pulse only.
- **Back-to-back:** `rst` press debounced during the HOLDOFF after an `s` pulse → `r` pulse issued exactly `HOLDOFF_CYCLES`+2 cycles after `s`, never overlapping it.
- **Reset mid-operation:** assert `reset` in the PULSE_S cycle → `s` = 0, `busy` = 0 and `pending` = 0 next cycle. If the button is still held, a new `s` pulse follows 19 cycles after reset deasserts.
